// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-back, write-allocate cache
// with tree pseudo-LRU replacement between a 16-bit CPU port and line memory.
module set_assoc_cache #(
    parameter int WAYS   = 2,
    parameter int SETS   = 8,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [1:0]        cache_byte_enable,
    input  logic [15:0]       cache_address,
    input  logic [15:0]       cache_wdata,
    output logic [15:0]       cache_rdata,
    output logic              cache_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [15:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = 16 - IDX - OFF;
    localparam int WB    = $clog2(WAYS);
    localparam int WORDS = LINE_W / 16;
    localparam int NODES = WAYS - 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

    state_e            state_q;
    logic [WB-1:0]     victim_q;
    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [TAG-1:0]    tag_q   [WAYS][SETS];
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];
    logic [NODES-1:0]  plru_q  [SETS];

    logic [TAG-1:0]    req_tag;
    logic [IDX-1:0]    req_idx;
    logic [OFF-2:0]    req_word;
    logic              req;
    logic              hit;
    logic              inv_found;
    logic [WB-1:0]     hit_way;
    logic [WB-1:0]     inv_way;
    logic [WB-1:0]     plru_way;
    logic [WB-1:0]     victim;
    logic [NODES-1:0]  plru_hit;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] merged;
    logic [15:0]       rd_word;
    logic              unused_addr_lsb;

    assign req_tag  = cache_address[15 -: TAG];
    assign req_idx  = cache_address[OFF +: IDX];
    assign req_word = cache_address[1 +: OFF-1];
    assign req      = cache_read | cache_write;
    // byte address bit 0 never selects anything: the port is word-wide
    assign unused_addr_lsb = cache_address[0];

    // tag compare, victim choice, PLRU-on-hit and write merge
    always_comb begin
        int   node;
        logic b;
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][req_idx] &&
                tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!inv_found && !valid_q[w][req_idx]) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
        end
        node     = 0;
        b        = 1'b0;
        plru_way = '0;
        for (int l = 0; l < WB; l++) begin
            b = 1'b0;
            for (int n = 0; n < NODES; n++)
                if (n == node) b = plru_q[req_idx][n];
            plru_way = WB'({plru_way, b});
            node     = 2 * node + 1 + int'(b);
        end
        victim = inv_found ? inv_way : plru_way;
        // walk the hit way's path, pointing each node away from it
        plru_hit = plru_q[req_idx];
        node     = 0;
        for (int l = 0; l < WB; l++) begin
            b = 1'(hit_way >> (WB - 1 - l));
            for (int n = 0; n < NODES; n++)
                if (n == node) plru_hit[n] = ~b;
            node = 2 * node + 1 + int'(b);
        end
        hit_line = data_q[hit_way][req_idx];
        merged   = hit_line;
        rd_word  = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (k == int'(req_word)) begin
                rd_word = hit_line[k*16 +: 16];
                if (cache_byte_enable[0])
                    merged[k*16 +: 8] = cache_wdata[7:0];
                if (cache_byte_enable[1])
                    merged[k*16+8 +: 8] = cache_wdata[15:8];
            end
        end
    end

    // controller FSM plus valid/dirty/PLRU bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++)
                plru_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        plru_q[req_idx] <= plru_hit;
                        if (cache_write && cache_byte_enable != 2'b00)
                            dirty_q[hit_way][req_idx] <= 1'b1;
                    end else if (req) begin
                        victim_q <= victim;
                        if (valid_q[victim][req_idx] &&
                            dirty_q[victim][req_idx])
                            state_q <= WRITEBACK;
                        else
                            state_q <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_resp) state_q <= FILL;
                end
                FILL: begin
                    if (mem_resp) begin
                        valid_q[victim_q][req_idx] <= 1'b1;
                        dirty_q[victim_q][req_idx] <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // line and tag storage: write hits merge, fills overwrite
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == IDLE && req && hit && cache_write) begin
                data_q[hit_way][req_idx] <= merged;
            end else if (state_q == FILL && mem_resp) begin
                data_q[victim_q][req_idx] <= mem_rdata;
                tag_q[victim_q][req_idx]  <= req_tag;
            end
        end
    end

    // memory port decoded from state, CPU response from the compare
    always_comb begin
        mem_read    = (state_q == FILL);
        mem_write   = (state_q == WRITEBACK);
        mem_address = '0;
        mem_wdata   = '0;
        if (state_q == WRITEBACK) begin
            mem_address = {tag_q[victim_q][req_idx], req_idx, OFF'(0)};
            mem_wdata   = data_q[victim_q][req_idx];
        end else if (state_q == FILL) begin
            mem_address = {req_tag, req_idx, OFF'(0)};
        end
        cache_resp  = reset_n && (state_q == IDLE) && req && hit;
        cache_rdata = cache_resp ? rd_word : '0;
    end
endmodule
